// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL bring-up / lock supervisor.
package pll_sup_pkg;

  localparam int ICP_W = 6;
  localparam int LPF_W = 3;

  typedef enum logic [2:0] {
    ST_RST,
    ST_WAIT,
    ST_STABLE,
    ST_LOCKED,
    ST_FAULT
  } pll_sup_state_t;

  // Width of a counter that must hold the largest of three cycle counts.
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_sup_chan.sv
// One supervised PLL channel: lock synchroniser, bring-up FSM, retry sweep.
module pll_sup_chan
  import pll_sup_pkg::*;
#(
  parameter int                NUM_PLL      = 2,
  parameter int                RST_CYCLES   = 16,
  parameter int                LOCK_TIMEOUT = 4096,
  parameter int                STABLE_CYC   = 256,
  parameter int                MAX_RETRY    = 4,
  parameter logic [ICP_W-1:0]  ICP_INIT     = 6'd16,
  parameter logic [ICP_W-1:0]  ICP_STEP     = 6'd4,
  parameter logic [LPF_W-1:0]  LPF_INIT     = 3'd2
) (
  input  logic             init_clk,
  input  logic             i_rst,
  input  logic             pll_lock,
  input  logic             retry_req,
  output logic             pll_rst,
  output logic [ICP_W-1:0] icpsel,
  output logic [LPF_W-1:0] lpfres,
  output logic             o_lock,
  output logic             fault
);

  localparam int CW = cnt_w(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYC);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYC - 1);
  localparam logic [3:0]    RETRY_LAST = 4'(MAX_RETRY - 1);

  pll_sup_state_t   state, state_n;
  logic [CW-1:0]    cnt, cnt_n;       // reset length, wait timer or stable run, by state
  logic [3:0]       retry, retry_n;
  logic [ICP_W-1:0] icp, icp_n;
  logic [ICP_W:0]   icp_sum;
  logic             sync1, lk;

  // Two-flop synchroniser for the asynchronous raw lock.
  always_ff @(posedge init_clk) begin
    if (i_rst) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      sync1 <= pll_lock;
      lk    <= sync1;
    end
  end

  assign icp_sum = {1'b0, icp} + {1'b0, ICP_STEP};

  // Next-state, counter and charge-pump sweep decisions.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    retry_n = retry;
    icp_n   = icp;
    case (state)
      ST_RST: begin
        if (cnt == RST_LAST) begin
          state_n = ST_WAIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_WAIT: begin
        // A lock seen on the timeout cycle still wins.
        if (lk) begin
          state_n = (STABLE_CYC == 1) ? ST_LOCKED : ST_STABLE;
          cnt_n   = CW'(1);
        end else if (cnt == TO_LAST) begin
          cnt_n   = '0;
          retry_n = retry + 4'd1;
          if (retry == RETRY_LAST) begin
            state_n = ST_FAULT;
          end else begin
            state_n = ST_RST;
            icp_n   = icp_sum[ICP_W] ? '1 : icp_sum[ICP_W-1:0];
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_STABLE: begin
        // A dropout only restarts the wait; it is not a failed attempt.
        if (!lk) begin
          state_n = ST_WAIT;
          cnt_n   = '0;
        end else if (cnt == STAB_LAST) begin
          state_n = ST_LOCKED;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_LOCKED: begin
        // Relock keeps the current icp and retry history.
        if (!lk) begin
          state_n = ST_RST;
          cnt_n   = '0;
        end
      end
      ST_FAULT: begin
        if (retry_req) begin
          state_n = ST_RST;
          cnt_n   = '0;
          retry_n = '0;
          icp_n   = ICP_INIT;
        end
      end
      default: begin
        state_n = ST_RST;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counters and registered outputs derived from the entered state.
  always_ff @(posedge init_clk) begin
    if (i_rst) begin
      state   <= ST_RST;
      cnt     <= '0;
      retry   <= '0;
      icp     <= ICP_INIT;
      pll_rst <= 1'b1;
      o_lock  <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      retry   <= retry_n;
      icp     <= icp_n;
      pll_rst <= (state_n == ST_RST) || (state_n == ST_FAULT);
      o_lock  <= (state_n == ST_LOCKED);
      fault   <= (state_n == ST_FAULT);
    end
  end

  assign icpsel = icp;
  assign lpfres = LPF_INIT;

endmodule

// File: rtl/pll_supervisor.sv
// Multi-channel PLL supervisor: one independent channel per PLL plus all_lock.
module pll_supervisor
  import pll_sup_pkg::*;
#(
  parameter int                NUM_PLL      = 2,
  parameter int                RST_CYCLES   = 16,
  parameter int                LOCK_TIMEOUT = 4096,
  parameter int                STABLE_CYC   = 256,
  parameter int                MAX_RETRY    = 4,
  parameter logic [ICP_W-1:0]  ICP_INIT     = 6'd16,
  parameter logic [ICP_W-1:0]  ICP_STEP     = 6'd4,
  parameter logic [LPF_W-1:0]  LPF_INIT     = 3'd2
) (
  input  logic                     init_clk,
  input  logic                     i_rst,
  input  logic [NUM_PLL-1:0]       pll_lock,
  input  logic [NUM_PLL-1:0]       retry_req,
  output logic [NUM_PLL-1:0]       pll_rst,
  output logic [ICP_W*NUM_PLL-1:0] icpsel,
  output logic [LPF_W*NUM_PLL-1:0] lpfres,
  output logic [NUM_PLL-1:0]       o_lock,
  output logic [NUM_PLL-1:0]       fault,
  output logic                     all_lock
);

  logic [NUM_PLL-1:0][ICP_W-1:0] icp_v;
  logic [NUM_PLL-1:0][LPF_W-1:0] lpf_v;

  for (genvar g = 0; g < NUM_PLL; g++) begin : g_chan
    pll_sup_chan #(
      .NUM_PLL     (NUM_PLL),
      .RST_CYCLES  (RST_CYCLES),
      .LOCK_TIMEOUT(LOCK_TIMEOUT),
      .STABLE_CYC  (STABLE_CYC),
      .MAX_RETRY   (MAX_RETRY),
      .ICP_INIT    (ICP_INIT),
      .ICP_STEP    (ICP_STEP),
      .LPF_INIT    (LPF_INIT)
    ) u_chan (
      .init_clk (init_clk),
      .i_rst    (i_rst),
      .pll_lock (pll_lock[g]),
      .retry_req(retry_req[g]),
      .pll_rst  (pll_rst[g]),
      .icpsel   (icp_v[g]),
      .lpfres   (lpf_v[g]),
      .o_lock   (o_lock[g]),
      .fault    (fault[g])
    );
  end

  assign icpsel   = icp_v;
  assign lpfres   = lpf_v;
  assign all_lock = &o_lock;

endmodule

// File: tb/tb_pll_supervisor.sv
// Scoreboard bench: expected per-channel output changes (cycle + values) are
// queued up front; a negedge monitor pops one entry per observed change.
module tb_pll_supervisor;

  localparam int END_CYC = 185;

  logic        init_clk = 1'b0;
  logic        i_rst    = 1'b1;
  logic [1:0]  pll_lock = 2'b00;
  logic [1:0]  retry_req = 2'b00;
  logic [1:0]  pll_rst, o_lock, fault;
  logic [11:0] icpsel;
  logic [5:0]  lpfres;
  logic        all_lock;

  // saturation instance: single channel starting near the top of the icp range
  logic        s_lock = 1'b0;
  logic        s_req  = 1'b0;
  logic        s_rst, s_olock, s_fault, s_all;
  logic [5:0]  s_icp;
  logic [2:0]  s_lpf;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct packed {
    int         cyc;
    logic [8:0] v;   // {pll_rst, o_lock, fault, icpsel}
  } exp_t;

  exp_t       sb [3][$];
  logic [8:0] prev [3];

  pll_supervisor #(
    .NUM_PLL(2), .RST_CYCLES(4), .LOCK_TIMEOUT(16), .STABLE_CYC(8),
    .MAX_RETRY(3), .ICP_INIT(6'd20), .ICP_STEP(6'd4), .LPF_INIT(3'd2)
  ) dut (
    .init_clk(init_clk), .i_rst(i_rst), .pll_lock(pll_lock), .retry_req(retry_req),
    .pll_rst(pll_rst), .icpsel(icpsel), .lpfres(lpfres), .o_lock(o_lock),
    .fault(fault), .all_lock(all_lock)
  );

  pll_supervisor #(
    .NUM_PLL(1), .RST_CYCLES(4), .LOCK_TIMEOUT(16), .STABLE_CYC(8),
    .MAX_RETRY(3), .ICP_INIT(6'd60), .ICP_STEP(6'd4), .LPF_INIT(3'd2)
  ) u_sat (
    .init_clk(init_clk), .i_rst(i_rst), .pll_lock(s_lock), .retry_req(s_req),
    .pll_rst(s_rst), .icpsel(s_icp), .lpfres(s_lpf), .o_lock(s_olock),
    .fault(s_fault), .all_lock(s_all)
  );

  always #5 init_clk = ~init_clk;

  // edge counter: after posedge e, cyc == e
  always @(posedge init_clk) cyc <= cyc + 1;

  function automatic logic [8:0] snap(input int n);
    if (n == 2) return {s_rst, s_olock, s_fault, s_icp};
    return {pll_rst[n], o_lock[n], fault[n], icpsel[6*n +: 6]};
  endfunction

  task automatic exp(input int n, input int c, input logic r, input logic l,
                     input logic f, input logic [5:0] icp);
    exp_t e;
    e.cyc = c;
    e.v   = {r, l, f, icp};
    sb[n].push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic at(input int e);
    while (cyc < e) @(negedge init_clk);
  endtask

  // monitor / scoreboard
  always @(negedge init_clk) begin
    logic [8:0] cur;
    exp_t       e;
    if (cyc == 2) begin
      chk("reset pll_rst", pll_rst, 3);
      chk("reset o_lock", o_lock, 0);
      chk("reset fault", fault, 0);
      chk("reset all_lock", all_lock, 0);
      chk("reset icpsel", icpsel, {6'd20, 6'd20});
      chk("reset lpfres", lpfres, {3'd2, 3'd2});
      chk("reset sat state", snap(2), {1'b1, 1'b0, 1'b0, 6'd60});
      for (int n = 0; n < 3; n++) prev[n] = snap(n);
    end else if (cyc > 2) begin
      for (int n = 0; n < 3; n++) begin
        cur = snap(n);
        if (cur !== prev[n]) begin
          tests++;
          if (sb[n].size() == 0) begin
            fails++;
            $display("FAIL ch%0d unexpected change at cycle %0d: rst/lock/fault/icp=%b/%b/%b/%0d",
                     n, cyc, cur[8], cur[7], cur[6], cur[5:0]);
          end else begin
            e = sb[n].pop_front();
            if (e.cyc != cyc || e.v !== cur) begin
              fails++;
              $display("FAIL ch%0d change: cycle %0d rst/lock/fault/icp=%b/%b/%b/%0d, expected cycle %0d %b/%b/%b/%0d",
                       n, cyc, cur[8], cur[7], cur[6], cur[5:0],
                       e.cyc, e.v[8], e.v[7], e.v[6], e.v[5:0]);
            end
          end
          prev[n] = cur;
        end
      end
      if (cyc == 80)  chk("all_lock one locked", all_lock, 0);
      if (cyc == 110) chk("all_lock both locked", all_lock, 1);
      if (cyc == 120) chk("all_lock after loss", all_lock, 0);
      if (cyc == END_CYC) begin
        for (int n = 0; n < 3; n++) chk($sformatf("ch%0d missing changes", n), sb[n].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  end

  // stimulus and expected output changes
  initial begin
    // ch0: clean lock, loss/relock, glitch, then reset during STABLE
    exp(0,   6, 0, 0, 0, 20);
    exp(0,  19, 0, 1, 0, 20);
    exp(0,  33, 1, 0, 0, 20);
    exp(0,  37, 0, 0, 0, 20);
    exp(0,  45, 0, 1, 0, 20);
    exp(0,  53, 1, 0, 0, 20);
    exp(0,  57, 0, 0, 0, 20);
    exp(0,  73, 0, 1, 0, 20);
    exp(0, 163, 1, 0, 0, 20);
    exp(0, 167, 0, 0, 0, 20);
    exp(0, 173, 1, 0, 0, 20);
    exp(0, 177, 0, 0, 0, 20);
    // ch1: sweep to fault, retry, lock after one failure, loss keeps history
    exp(1,   6, 0, 0, 0, 20);
    exp(1,  22, 1, 0, 0, 24);
    exp(1,  26, 0, 0, 0, 24);
    exp(1,  42, 1, 0, 0, 28);
    exp(1,  46, 0, 0, 0, 28);
    exp(1,  62, 1, 0, 1, 28);
    exp(1,  76, 1, 0, 0, 20);
    exp(1,  80, 0, 0, 0, 20);
    exp(1,  96, 1, 0, 0, 24);
    exp(1, 100, 0, 0, 0, 24);
    exp(1, 110, 0, 1, 0, 24);
    exp(1, 118, 1, 0, 0, 24);
    exp(1, 122, 0, 0, 0, 24);
    exp(1, 138, 1, 0, 0, 28);
    exp(1, 142, 0, 0, 0, 28);
    exp(1, 158, 1, 0, 1, 28);
    exp(1, 173, 1, 0, 0, 20);
    exp(1, 177, 0, 0, 0, 20);
    // saturation channel: 60 -> 63 -> 63 -> FAULT
    exp(2,   6, 0, 0, 0, 60);
    exp(2,  22, 1, 0, 0, 63);
    exp(2,  26, 0, 0, 0, 63);
    exp(2,  42, 1, 0, 0, 63);
    exp(2,  46, 0, 0, 0, 63);
    exp(2,  62, 1, 0, 1, 63);
    exp(2, 173, 1, 0, 0, 60);
    exp(2, 177, 0, 0, 0, 60);

    at(2);   i_rst = 1'b0;
    at(9);   pll_lock[0] = 1'b1;
    at(30);  pll_lock[0] = 1'b0;
    at(33);  pll_lock[0] = 1'b1;
    at(50);  pll_lock[0] = 1'b0;
    at(57);  pll_lock[0] = 1'b1;
    at(62);  pll_lock[0] = 1'b0;
    at(63);  pll_lock[0] = 1'b1;
    at(75);  retry_req = 2'b11;   // ch0 is LOCKED and must ignore it
    at(76);  retry_req = 2'b00;
    at(100); pll_lock[1] = 1'b1;
    at(115); pll_lock[1] = 1'b0;
    at(160); pll_lock[0] = 1'b0;
    at(167); pll_lock[0] = 1'b1;
    at(172); begin i_rst = 1'b1; pll_lock[0] = 1'b0; end
    at(173); i_rst = 1'b0;
  end

endmodule
